uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter byte stream between NUM_REQ requesters (CPU core, debug monitor, boot status, ...) inside risc_logic.
- Clocked by the 7.3728 MHz system clock.
- Packet-locked round-robin arbitration: a granted requester keeps the transmitter until it hands over a byte flagged last, so messages never interleave.
- Sits between requester byte streams and the UART TX serializer; valid/ready on both sides.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Optional idle-owner forced release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_g_q, last_g_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W:0]       pick_c;
  logic                 tx_valid_c;
  logic                 hs_c;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // First requester above the previous owner, wrapping; MSB flags "found".
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[IDX_W] && v[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign pick_c = rr_pick(req_valid_i, last_g_q);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      last_g_q <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_g_q <= last_g_d;
      grant_q  <= grant_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state and pass-through datapath; tx_valid only looks at the owner's valid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_g_d    = last_g_q;
    grant_d     = grant_q;
    tx_valid_c  = 1'b0;
    req_ready_c = '0;
    hs_c        = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_c[IDX_W]) begin
          state_d = S_LOCKED;
          owner_d = pick_c[IDX_W-1:0];
          grant_d = NUM_REQ'(1) << pick_c[IDX_W-1:0];
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_LOCKED: begin
        tx_valid_c           = req_valid_i[owner_q];
        req_ready_c[owner_q] = tx_ready_i;
        hs_c                 = tx_valid_c & tx_ready_i;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = req_valid_i[owner_q] ? '0 : cnt_q + CNT_W'(1);
`endif
        if (hs_c && req_last_i[owner_q]) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          last_g_d = owner_q;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!req_valid_i[owner_q] && cnt_q == CNT_MAX) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          last_g_d  = owner_q;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid_o  = tx_valid_c;
  assign req_ready_o = req_ready_c;
  assign tx_data_o   = data_arr[owner_q];
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == S_LOCKED);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=2, DATA_WIDTH=8).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int GAP = 12;
`else
  localparam int GAP = 20;
`endif

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .grant_o    (grant),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_txv"},   32'(tx_valid),  32'h0);
    chk({tag, "_grant"}, 32'(grant),     32'h0);
    chk({tag, "_busy"},  32'(busy),      32'h0);
    chk({tag, "_rdy"},   32'(req_ready), 32'h0);
  endtask

  task automatic expect_xfer(input string tag, input logic [7:0] d, input logic [1:0] g);
    @(negedge clk);
    chk({tag, "_txv"},   32'(tx_valid),  32'h1);
    chk({tag, "_data"},  32'(tx_data),   32'(d));
    chk({tag, "_grant"}, 32'(grant),     32'(g));
    chk({tag, "_rdy"},   32'(req_ready), 32'(g));
    chk({tag, "_busy"},  32'(busy),      32'h1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_txv",   32'(tx_valid), 32'h0);
    chk("rst_rdy",   32'(req_ready), 32'h0);
    chk("rst_to",    32'(timeout), 32'h0);
    cyc();
    rst = 1'b0;

    // Two 3-byte packets, requester 0 first out of reset
    req_valid = 2'b11; req_data = 16'h6141; req_last = 2'b00; tx_ready = 1'b1;
    expect_idle("p1_arb");
    cyc(); expect_xfer("p1_b0", 8'h41, 2'b01);
    cyc(); req_data[7:0] = 8'h42; expect_xfer("p1_b1", 8'h42, 2'b01);
    cyc(); req_data[7:0] = 8'h43; req_last[0] = 1'b1; expect_xfer("p1_b2", 8'h43, 2'b01);
    cyc(); req_valid[0] = 1'b0; req_last[0] = 1'b0; expect_idle("p1_bubble");
    cyc(); expect_xfer("p2_b0", 8'h61, 2'b10);
    cyc(); req_data[15:8] = 8'h62; expect_xfer("p2_b1", 8'h62, 2'b10);
    cyc(); req_data[15:8] = 8'h63; req_last[1] = 1'b1; expect_xfer("p2_b2", 8'h63, 2'b10);
    cyc(); req_valid = 2'b00; req_last = 2'b00; expect_idle("p2_end");

    // Fairness: one-byte packets from both, strictly alternating
    cyc(); req_valid = 2'b11; req_data = 16'h3130; req_last = 2'b11;
    for (int k = 0; k < 8; k++) begin
      expect_idle("fair_gap");
      cyc();
      if (k % 2 == 0) expect_xfer("fair_r0", 8'h30, 2'b01);
      else            expect_xfer("fair_r1", 8'h31, 2'b10);
      cyc();
    end
    req_valid = 2'b00; req_last = 2'b00;

    // Stall: serializer not ready for 10 cycles
    req_valid = 2'b01; req_data[7:0] = 8'h55; req_last = 2'b01; tx_ready = 1'b0;
    expect_idle("stall_arb");
    cyc();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_txv",  32'(tx_valid), 32'h1);
      chk("stall_data", 32'(tx_data), 32'h55);
      chk("stall_rdy",  32'(req_ready), 32'h0);
      cyc();
    end
    tx_ready = 1'b1;
    expect_xfer("stall_rel", 8'h55, 2'b01);
    cyc(); req_valid = 2'b00; req_last = 2'b00; expect_idle("stall_end");

    // Mid-packet gap: owner keeps grant while the other requester waits
    cyc(); req_valid = 2'b01; req_data = 16'h7710; req_last = 2'b00;
    expect_idle("gap_arb");
    cyc(); expect_xfer("gap_b0", 8'h10, 2'b01);
    cyc(); req_valid = 2'b10; req_last = 2'b10;
    for (int k = 0; k < GAP; k++) begin
      @(negedge clk);
      chk("gap_txv",   32'(tx_valid), 32'h0);
      chk("gap_grant", 32'(grant), 32'h1);
      chk("gap_rdy",   32'(req_ready), 32'h1);
      chk("gap_to",    32'(timeout), 32'h0);
      cyc();
    end
    req_valid = 2'b11; req_data[7:0] = 8'h11; req_last = 2'b11;
    expect_xfer("gap_b1", 8'h11, 2'b01);
    cyc(); req_valid = 2'b10; expect_idle("gap_bubble");
    cyc(); expect_xfer("gap_r1", 8'h77, 2'b10);
    cyc(); req_valid = 2'b00; req_last = 2'b00;

    // Reset mid-packet; pointer primed to favour requester 1 before reset
    req_valid = 2'b01; req_data[7:0] = 8'hC0; req_last = 2'b01;
    expect_idle("rp_arb");
    cyc(); expect_xfer("rp_prime", 8'hC0, 2'b01);
    cyc(); req_last = 2'b00; req_data[7:0] = 8'hA1;
    expect_idle("rp_arb2");
    cyc(); expect_xfer("rp_b0", 8'hA1, 2'b01);
    cyc(); req_data[7:0] = 8'hA2; expect_xfer("rp_b1", 8'hA2, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rp_async_txv",   32'(tx_valid), 32'h0);
    chk("rp_async_grant", 32'(grant), 32'h0);
    chk("rp_async_busy",  32'(busy), 32'h0);
    req_valid = 2'b11; req_data = 16'hD1D0; req_last = 2'b11;
    cyc(); rst = 1'b0;
    expect_idle("rp_arb3");
    cyc(); expect_xfer("rp_win0", 8'hD0, 2'b01);
    cyc(); req_valid = 2'b10; expect_idle("rp_bubble");
    cyc(); expect_xfer("rp_r1", 8'hD1, 2'b10);
    cyc(); req_valid = 2'b00; req_last = 2'b00;

    // Owner goes silent after a non-last byte
    req_valid = 2'b01; req_data = 16'hF0E0; req_last = 2'b10;
    expect_idle("to_arb");
    cyc(); expect_xfer("to_b0", 8'hE0, 2'b01);
    cyc(); req_valid = 2'b10;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("to_wait_pulse", 32'(timeout), 32'h0);
      chk("to_wait_grant", 32'(grant), 32'h1);
      cyc();
    end
    @(negedge clk);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_grant", 32'(grant), 32'h0);
    chk("to_busy",  32'(busy), 32'h0);
    cyc();
    expect_xfer("to_r1", 8'hF0, 2'b10);
    chk("to_pulse_end", 32'(timeout), 32'h0);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_pulse", 32'(timeout), 32'h0);
      chk("hold_grant", 32'(grant), 32'h1);
      cyc();
    end
    req_valid = 2'b11; req_data[7:0] = 8'hE1; req_last = 2'b11;
    expect_xfer("hold_b1", 8'hE1, 2'b01);
    cyc(); req_valid = 2'b10; expect_idle("hold_bubble");
    cyc(); expect_xfer("hold_r1", 8'hF0, 2'b10);
`endif
    cyc(); req_valid = 2'b00; req_last = 2'b00;
    expect_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
